// File: rtl/output_layer_sequencer_if.sv
// Bundle of signals between the output-layer sequencer and its surroundings:
// the start/busy control, the MAC job handshake, the packed score bus to the
// argmax unit and the result valid/ready handshake.
interface output_layer_sequencer_if #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 20,
  parameter int IDX_W       = 4
);
  logic                           start;
  logic                           busy;
  logic                           mac_start;
  logic [IDX_W-1:0]               neuron_idx;
  logic                           mac_done;
  logic [SCORE_W-1:0]             mac_score;
  logic [NUM_CLASSES*SCORE_W-1:0] scores_packed;
  logic [IDX_W-1:0]               max_idx_in;
  logic                           result_valid;
  logic                           result_ready;
  logic [IDX_W-1:0]               result_idx;

  // Environment side: control, MAC model, argmax unit and result consumer.
  modport master (
    output start, mac_done, mac_score, max_idx_in, result_ready,
    input  busy, mac_start, neuron_idx, scores_packed, result_valid, result_idx
  );

  // Sequencer side.
  modport slave (
    input  start, mac_done, mac_score, max_idx_in, result_ready,
    output busy, mac_start, neuron_idx, scores_packed, result_valid, result_idx
  );
endinterface

// File: rtl/output_layer_sequencer.sv
// Output-layer sequencer: issues one MAC job per class, buffers the signed
// scores for the external argmax, latches the winning class once every score
// is in, and offers it downstream through a valid/ready handshake.
module output_layer_sequencer #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_W     = 20,
  parameter int IDX_W       = 4
) (
  input logic clk,
  input logic rst,
  output_layer_sequencer_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    LATCH,
    HOLD
  } state_t;

  state_t                   state_q;
  logic                     busy_q;
  logic                     mac_start_q;
  logic [IDX_W-1:0]         neuron_idx_q;
  logic                     result_valid_q;
  logic [IDX_W-1:0]         result_idx_q;
  logic [SCORE_W-1:0]       score_q [NUM_CLASSES];
  logic [NUM_CLASSES*SCORE_W-1:0] scores_flat;

  // Control FSM with registered outputs; also owns the score buffer writes.
  // mac_start and busy are set on the transition into the state they
  // describe, so each output is valid in the same cycle as its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      mac_start_q    <= 1'b0;
      neuron_idx_q   <= '0;
      result_valid_q <= 1'b0;
      result_idx_q   <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) begin
        score_q[i] <= '0;
      end
    end else begin
      mac_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            neuron_idx_q <= '0;
            mac_start_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ISSUE;
          end
        end
        ISSUE: begin
          // A mac_done arriving together with mac_start is not for this job.
          state_q <= WAIT;
        end
        WAIT: begin
          if (bus.mac_done) begin
            score_q[neuron_idx_q] <= bus.mac_score;
            if (neuron_idx_q == LAST_IDX) begin
              state_q <= LATCH;
            end else begin
              neuron_idx_q <= neuron_idx_q + IDX_W'(1);
              mac_start_q  <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        LATCH: begin
          // The last score became visible on scores_packed this cycle, so the
          // combinational argmax has settled on the full set.
          result_idx_q   <= bus.max_idx_in;
          result_valid_q <= 1'b1;
          state_q        <= HOLD;
        end
        HOLD: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Pack the score buffer into the argmax bus, slot i at [i*SCORE_W +: SCORE_W].
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_pack
    assign scores_flat[gi*SCORE_W +: SCORE_W] = score_q[gi];
  end

  assign bus.scores_packed = scores_flat;
  assign bus.busy          = busy_q;
  assign bus.mac_start     = mac_start_q;
  assign bus.neuron_idx    = neuron_idx_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.result_idx    = result_idx_q;

endmodule

// File: tb/tb_output_layer_sequencer.sv
// Bench for output_layer_sequencer: a MAC responder, a combinational argmax
// and a score-slot model that is compared against the DUT every cycle, plus
// directed runs with hand-computed winners and timing.
module tb_output_layer_sequencer;
  localparam int NC = 10;
  localparam int SW = 20;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  output_layer_sequencer_if #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) bus ();

  output_layer_sequencer #(.NUM_CLASSES(NC), .SCORE_W(SW), .IDX_W(IW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  logic signed [SW-1:0] tbl   [NC];   // scores the MAC returns for the current run
  logic signed [SW-1:0] model [NC];   // what the score buffer must hold
  int fixed_lat = 1;
  bit rand_lat  = 1'b0;
  bit spur_en   = 1'b0;
  bit mon_en    = 1'b0;
  int job_k     = 0;
  int pulses    = 0;
  int am_best;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NC*SW-1:0] act,
                         input logic [NC*SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int ref_argmax(input logic signed [SW-1:0] s [NC]);
    int best;
    best = 0;
    for (int i = 1; i < NC; i++) begin
      if (s[i] > s[best]) best = i;
    end
    return best;
  endfunction

  function automatic logic [NC*SW-1:0] pack(input logic signed [SW-1:0] s [NC]);
    logic [NC*SW-1:0] r;
    r = '0;
    for (int i = 0; i < NC; i++) r[i*SW +: SW] = s[i];
    return r;
  endfunction

  // External combinational argmax: signed, lowest index wins ties.
  always_comb begin
    am_best = 0;
    for (int i = 1; i < NC; i++) begin
      if ($signed(bus.scores_packed[i*SW +: SW]) > $signed(bus.scores_packed[am_best*SW +: SW]))
        am_best = i;
    end
    bus.max_idx_in = IW'(am_best);
  end

  // MAC responder: answers every mac_start after its latency with the table
  // score of that job, and optionally injects spurious mac_done pulses in
  // IDLE, ISSUE and HOLD.
  initial begin
    int pend;
    int pend_slot;
    int wr_slot;
    bit wr_pend;
    bit legit;
    logic signed [SW-1:0] pend_val;
    logic signed [SW-1:0] wr_val;
    pend = 0; pend_slot = 0; wr_slot = 0; wr_pend = 1'b0; legit = 1'b0;
    pend_val = '0; wr_val = '0;
    for (int i = 0; i < NC; i++) model[i] = '0;
    bus.mac_done  = 1'b0;
    bus.mac_score = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < NC; i++) model[i] = '0;
        pend = 0; wr_pend = 1'b0; job_k = 0;
      end else if (wr_pend) begin
        model[wr_slot] = wr_val;
        wr_pend = 1'b0;
      end
      #1;
      bus.mac_done  = 1'b0;
      bus.mac_score = '0;
      legit = 1'b0;
      if (!rst) begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus.mac_done  = 1'b1;
            bus.mac_score = pend_val;
            legit   = 1'b1;
            wr_pend = 1'b1;
            wr_slot = pend_slot;
            wr_val  = pend_val;
          end
        end
        if (bus.mac_start) begin
          if (job_k == NC) job_k = 0;
          chk("neuron_idx", bus.neuron_idx, job_k);
          pend      = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
          pend_val  = tbl[job_k];
          pend_slot = job_k;
          job_k++;
          pulses++;
        end
        if (spur_en && !legit && (bus.mac_start || !bus.busy || bus.result_valid)
            && ($urandom_range(0, 1) == 1)) begin
          bus.mac_done  = 1'b1;
          bus.mac_score = SW'($urandom);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  logic prev_ms = 1'b0;
  logic prev_rv = 1'b0;
  logic [IW-1:0] held_idx = '0;
  always @(negedge clk) begin
    if (mon_en) begin
      chk_vec("scores_packed", bus.scores_packed, pack(model));
      if (bus.mac_start) begin
        chk("mac_start_busy", bus.busy, 1);
        chk("mac_start_single", prev_ms, 0);
      end
      if (bus.result_valid) begin
        chk("result_idx_model", bus.result_idx, ref_argmax(model));
        if (prev_rv) chk("result_idx_stable", bus.result_idx, held_idx);
      end
      prev_ms  = bus.mac_start;
      prev_rv  = bus.result_valid;
      held_idx = bus.result_idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < NC; i++) tbl[i] = SW'(v);
  endtask

  // One complete run; returns at #2 after the handshake edge (DUT in IDLE).
  task automatic run(input string tag, input int lat, input bit rl, input int ready_delay,
                     input bit start_in_hold, input int exp_idx);
    int cyc;
    fixed_lat = lat;
    rand_lat  = rl;
    pulses    = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    chk({tag, "_busy_c1"}, bus.busy, 1);
    chk({tag, "_issue0_c1"}, bus.mac_start, 1);
    while (!bus.result_valid && cyc < 400) begin
      tick();
      cyc++;
    end
    chk({tag, "_result_valid_seen"}, bus.result_valid, 1);
    if (!rl) chk({tag, "_result_valid_cycle"}, cyc, 12 + 10 * lat);
    chk({tag, "_mac_start_pulses"}, pulses, NC);
    chk({tag, "_result_idx"}, bus.result_idx, exp_idx);
    for (int i = 0; i < ready_delay; i++) begin
      if (start_in_hold && i == 2) bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk({tag, "_hold_valid"}, bus.result_valid, 1);
      chk({tag, "_hold_idx"}, bus.result_idx, exp_idx);
    end
    bus.result_ready = 1'b1;
    if (start_in_hold) bus.start = 1'b1;
    tick();
    bus.result_ready = 1'b0;
    bus.start = 1'b0;
    chk({tag, "_valid_cleared"}, bus.result_valid, 0);
    chk({tag, "_idle_after_ack"}, bus.busy, 0);
    $display("run %s: lat=%0d result_idx=%0d expected=%0d", tag, lat, bus.result_idx, exp_idx);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    set_all(0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_mac_start", bus.mac_start, 0);
    chk("reset_result_valid", bus.result_valid, 0);
    chk("reset_result_idx", bus.result_idx, 0);
    chk("reset_neuron_idx", bus.neuron_idx, 0);
    chk_vec("reset_scores", bus.scores_packed, '0);

    // 1: reset while waiting on the fifth job, four scores already stored.
    for (int i = 0; i < NC; i++) tbl[i] = SW'(i + 1);
    fixed_lat = 4;
    rand_lat  = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (job_k != 5 && n < 200) begin
      tick();
      n++;
    end
    chk("rst_reached_job4", job_k, 5);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_busy", bus.busy, 0);
    chk("midrun_rst_mac_start", bus.mac_start, 0);
    chk("midrun_rst_result_valid", bus.result_valid, 0);
    chk("midrun_rst_neuron_idx", bus.neuron_idx, 0);
    chk_vec("midrun_rst_scores", bus.scores_packed, '0);
    $display("reset in WAIT: busy=%0d scores=%h", bus.busy, bus.scores_packed);
    tick();

    // 2: basic run, L=1, score[i]=10*i with score[7]=5000.
    for (int i = 0; i < NC; i++) tbl[i] = SW'(10 * i);
    tbl[7] = SW'(5000);
    chk("pin_basic", ref_argmax(tbl), 7);
    run("basic", 1, 1'b0, 0, 1'b0, 7);
    tick();

    // 3: ties and sign.
    set_all(-3);
    tbl[2] = SW'(100);
    tbl[6] = SW'(100);
    chk("pin_tie", ref_argmax(tbl), 2);
    run("tie", 1, 1'b0, 0, 1'b0, 2);
    set_all(-100);
    tbl[9] = SW'(-1);
    chk("pin_neg", ref_argmax(tbl), 9);
    run("neg", 2, 1'b0, 0, 1'b0, 9);

    // 4: backpressure with start pulses in HOLD and in the handshake cycle.
    for (int i = 0; i < NC; i++) tbl[i] = SW'(i - 50);
    tbl[4] = SW'(300);
    run("backpressure", 3, 1'b0, 5, 1'b1, 4);
    tick();
    chk("start_in_hold_ignored_busy", bus.busy, 0);
    chk("start_in_hold_ignored_issue", bus.mac_start, 0);

    // 5: random latency, spurious mac_done in IDLE/ISSUE/HOLD.
    spur_en = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NC; i++) tbl[i] = SW'($urandom);
      run("random", 1, 1'b1, 3, 1'b0, ref_argmax(tbl));
      tick();
    end
    spur_en = 1'b0;

    // 6: back-to-back; the second run must overwrite every slot.
    for (int i = 0; i < NC; i++) tbl[i] = SW'(1000 + i);
    tbl[3] = SW'(9000);
    run("b2b_first", 1, 1'b0, 0, 1'b0, 3);
    for (int i = 0; i < NC; i++) tbl[i] = SW'(-200 - i);
    tbl[0] = SW'(-7);
    run("b2b_second", 1, 1'b0, 1, 1'b0, 0);
    chk_vec("b2b_slots", bus.scores_packed, pack(tbl));

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
